// File: rtl/tilt_encoder.sv
// Accelerometer-to-tilt encoder: block-averages X/Y samples and drives the ball block's direction and threshold inputs.
// Optional stale-sensor timeout is enabled by defining TILT_STALE_TIMEOUT_EN.
module tilt_encoder #(
  parameter int SAMPLE_WIDTH = 12,
  parameter int AVG_LOG2     = 2,
  parameter int SCALE_SHIFT  = 4,
  parameter int DEAD_ON      = 16,
  parameter int DEAD_OFF     = 8,
  parameter int STALE_CYCLES = 50000000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sample_valid,
  output logic                    sample_ready,
  input  logic [SAMPLE_WIDTH-1:0] x_sample,
  input  logic [SAMPLE_WIDTH-1:0] y_sample,
  output logic                    x_increment,
  output logic                    x_decrement,
  output logic                    y_increment,
  output logic                    y_decrement,
  output logic [7:0]              x_threshold,
  output logic [7:0]              y_threshold,
  output logic                    update_valid
);

  localparam int AW = SAMPLE_WIDTH + AVG_LOG2;
  localparam int CW = AVG_LOG2 + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'((1 << AVG_LOG2) - 1);
  localparam logic signed [AW-1:0] ON_POS  = AW'(DEAD_ON);
  localparam logic signed [AW-1:0] ON_NEG  = AW'(-DEAD_ON);
  localparam logic signed [AW-1:0] OFF_POS = AW'(DEAD_OFF);
  localparam logic signed [AW-1:0] OFF_NEG = AW'(-DEAD_OFF);

  if (AVG_LOG2 < 0 || AVG_LOG2 > 4 || DEAD_OFF >= DEAD_ON || STALE_CYCLES < 1 || SAMPLE_WIDTH < 9) begin : g_param_check
    $error("tilt_encoder: illegal parameter combination");
  end

  typedef enum logic [1:0] {INIT, ACCUM, UPDATE} top_state_t;
  typedef enum logic [1:0] {NEUTRAL, POS, NEG} dir_state_t;

  top_state_t      state_reg, state_next;
  logic [CW-1:0]   cnt_reg;
  logic            transfer;
  logic            stale_hit;
  logic            in_update;

  assign transfer  = sample_valid && (state_reg == ACCUM);
  assign in_update = (state_reg == UPDATE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= INIT;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next   = state_reg;
    sample_ready = 1'b0;
    case (state_reg)
      INIT:   state_next = ACCUM;
      ACCUM: begin
        sample_ready = 1'b1;
        if (transfer && cnt_reg == LAST_IDX) state_next = UPDATE;
      end
      UPDATE: state_next = ACCUM;
      default: state_next = INIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                      cnt_reg <= '0;
    else if (in_update || stale_hit) cnt_reg <= '0;
    else if (transfer)              cnt_reg <= cnt_reg + CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) update_valid <= 1'b0;
    else       update_valid <= in_update || stale_hit;
  end

`ifdef TILT_STALE_TIMEOUT_EN
  localparam int SCW = $clog2(STALE_CYCLES + 1);
  localparam logic [SCW-1:0] STALE_MAX = SCW'(STALE_CYCLES);
  logic [SCW-1:0] stale_cnt_reg;

  // Saturating at STALE_MAX makes the forced-neutral event fire exactly once per idle stretch.
  assign stale_hit = !transfer && (stale_cnt_reg == STALE_MAX - SCW'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          stale_cnt_reg <= '0;
    else if (transfer)                  stale_cnt_reg <= '0;
    else if (stale_cnt_reg != STALE_MAX) stale_cnt_reg <= stale_cnt_reg + SCW'(1);
  end
`else
  assign stale_hit = 1'b0;
`endif

  logic [SAMPLE_WIDTH-1:0] sample_in [2];
  logic                    inc_out   [2];
  logic                    dec_out   [2];
  logic [7:0]              thr_out   [2];

  assign sample_in[0] = x_sample;
  assign sample_in[1] = y_sample;

  for (genvar gi = 0; gi < 2; gi++) begin : g_axis
    logic signed [AW-1:0] acc_reg;
    logic signed [AW-1:0] ext;
    logic signed [AW-1:0] avg;
    logic signed [AW-1:0] scaled;
    logic [AW:0]          sum;
    logic [7:0]           thr_calc;
    logic [7:0]           thr_reg;
    dir_state_t           dir_reg, dir_next;

    assign ext    = AW'($signed(sample_in[gi]));
    assign avg    = acc_reg >>> AVG_LOG2;
    assign scaled = avg >>> SCALE_SHIFT;
    assign sum    = {scaled[AW-1], scaled} + (AW+1)'(128);

    // sum[AW] is the sign of scaled+128; any set bit above bit 7 on a positive sum means > 255.
    always_comb begin
      thr_calc = sum[7:0];
      if (sum[AW])           thr_calc = 8'd0;
      else if (|sum[AW-1:8]) thr_calc = 8'd255;
    end

    always_comb begin
      dir_next = dir_reg;
      case (dir_reg)
        NEUTRAL: begin
          if (scaled >= ON_POS)      dir_next = POS;
          else if (scaled <= ON_NEG) dir_next = NEG;
        end
        POS: begin
          if (scaled <= ON_NEG)       dir_next = NEG;
          else if (scaled < OFF_POS)  dir_next = NEUTRAL;
        end
        NEG: begin
          if (scaled >= ON_POS)       dir_next = POS;
          else if (scaled > OFF_NEG)  dir_next = NEUTRAL;
        end
        default: dir_next = NEUTRAL;
      endcase
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset)                       acc_reg <= '0;
      else if (in_update || stale_hit) acc_reg <= '0;
      else if (transfer)               acc_reg <= acc_reg + ext;
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        dir_reg <= NEUTRAL;
        thr_reg <= 8'd128;
      end else if (stale_hit) begin
        dir_reg <= NEUTRAL;
        thr_reg <= 8'd128;
      end else if (in_update) begin
        dir_reg <= dir_next;
        thr_reg <= thr_calc;
      end
    end

    assign inc_out[gi] = (dir_reg == POS);
    assign dec_out[gi] = (dir_reg == NEG);
    assign thr_out[gi] = thr_reg;
  end

  assign x_increment = inc_out[0];
  assign x_decrement = dec_out[0];
  assign y_increment = inc_out[1];
  assign y_decrement = dec_out[1];
  assign x_threshold = thr_out[0];
  assign y_threshold = thr_out[1];

endmodule

// File: tb/tb_tilt_encoder.sv
// Directed bench for tilt_encoder: averaging, scaling/saturation, hysteresis, handshake and reset.
// The idle-period section adapts to TILT_STALE_TIMEOUT_EN.
module tb_tilt_encoder;
  localparam int SW = 12;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          sample_valid = 1'b0;
  logic          sample_ready;
  logic [SW-1:0] x_sample = '0;
  logic [SW-1:0] y_sample = '0;
  logic          x_increment, x_decrement, y_increment, y_decrement;
  logic [7:0]    x_threshold, y_threshold;
  logic          update_valid;

  int n_checks = 0;
  int n_fail   = 0;

  tilt_encoder #(
    .SAMPLE_WIDTH(SW), .AVG_LOG2(2), .SCALE_SHIFT(4),
    .DEAD_ON(16), .DEAD_OFF(8), .STALE_CYCLES(20)
  ) dut (
    .clk(clk), .reset(reset),
    .sample_valid(sample_valid), .sample_ready(sample_ready),
    .x_sample(x_sample), .y_sample(y_sample),
    .x_increment(x_increment), .x_decrement(x_decrement),
    .y_increment(y_increment), .y_decrement(y_decrement),
    .x_threshold(x_threshold), .y_threshold(y_threshold),
    .update_valid(update_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Presents one sample from a falling edge and returns just after the rising edge that accepts it.
  task automatic send_sample(input int xv, input int yv);
    @(negedge clk);
    sample_valid = 1'b1;
    x_sample = SW'(xv);
    y_sample = SW'(yv);
    for (int k = 0; k < 50 && !sample_ready; k++) @(negedge clk);
    check("ready_wait", int'(sample_ready), 1);
    @(posedge clk);
  endtask

  task automatic send_block(input int xv, input int yv);
    for (int i = 0; i < 4; i++) send_sample(xv, yv);
  endtask

  // valid stays high with the last sample through UPDATE, so a double count would corrupt the next block.
  task automatic check_update(input string tag, input int xt, input int xi, input int xd,
                              input int yt, input int yi, input int yd);
    @(negedge clk);
    check({tag, "_ready_in_update"}, int'(sample_ready), 0);
    check({tag, "_uv_early"}, int'(update_valid), 0);
    @(negedge clk);
    sample_valid = 1'b0;
    check({tag, "_uv"}, int'(update_valid), 1);
    check({tag, "_x_thr"}, int'(x_threshold), xt);
    check({tag, "_x_inc"}, int'(x_increment), xi);
    check({tag, "_x_dec"}, int'(x_decrement), xd);
    check({tag, "_y_thr"}, int'(y_threshold), yt);
    check({tag, "_y_inc"}, int'(y_increment), yi);
    check({tag, "_y_dec"}, int'(y_decrement), yd);
    $display("update %s: x_thr=%0d x_inc=%0d x_dec=%0d y_thr=%0d y_inc=%0d y_dec=%0d",
             tag, x_threshold, x_increment, x_decrement, y_threshold, y_increment, y_decrement);
    @(negedge clk);
    check({tag, "_uv_one_cycle"}, int'(update_valid), 0);
  endtask

  initial begin
    int pulses;
    int pulse_at;

    #12;
    check("rst_ready", int'(sample_ready), 0);
    check("rst_x_thr", int'(x_threshold), 128);
    check("rst_y_thr", int'(y_threshold), 128);
    check("rst_incdec", int'({x_increment, x_decrement, y_increment, y_decrement}), 0);
    check("rst_uv", int'(update_valid), 0);
    @(negedge clk);
    reset = 1'b0;

    send_block(800, 0);
    check_update("b800", 178, 1, 0, 128, 0, 0);

    send_block(-2048, 2047);
    check_update("sat", 0, 0, 1, 255, 1, 0);

    // Two samples of a partial block, then an asynchronous reset in mid-cycle.
    send_sample(2047, 2047);
    send_sample(2047, 2047);
    @(negedge clk);
    reset = 1'b1;
    sample_valid = 1'b0;
    #1;
    check("arst_x_thr", int'(x_threshold), 128);
    check("arst_y_thr", int'(y_threshold), 128);
    check("arst_incdec", int'({x_increment, x_decrement, y_increment, y_decrement}), 0);
    check("arst_ready", int'(sample_ready), 0);
    check("arst_uv", int'(update_valid), 0);
    $display("reset asserted mid-block: x_thr=%0d y_thr=%0d", x_threshold, y_threshold);
    @(negedge clk);
    reset = 1'b0;

    send_block(800, 0);
    check_update("post_rst", 178, 1, 0, 128, 0, 0);
    send_block(160, 0);
    check_update("hyst_stay", 138, 1, 0, 128, 0, 0);
    send_block(96, 0);
    check_update("hyst_off", 134, 0, 0, 128, 0, 0);
    send_block(-320, 0);
    check_update("hyst_neg", 108, 0, 1, 128, 0, 0);
    send_block(0, 0);
    check_update("zero", 128, 0, 0, 128, 0, 0);

    // Y average -250 floors to scaled -16, landing exactly on the NEG entry point.
    send_sample(100, -100);
    send_sample(200, -200);
    send_sample(300, -300);
    send_sample(400, -400);
    check_update("mixed", 143, 0, 0, 112, 0, 1);
    send_block(0, 0);
    check_update("no_double", 128, 0, 0, 128, 0, 0);

    send_block(800, 0);
    check_update("pre_idle", 178, 1, 0, 128, 0, 0);

    pulses = 0;
    pulse_at = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (update_valid) begin
        pulses++;
        if (pulse_at < 0) pulse_at = k;
      end
    end
`ifdef TILT_STALE_TIMEOUT_EN
    check("stale_pulses", pulses, 1);
    check("stale_pulse_time", pulse_at, 18);
    check("stale_x_thr", int'(x_threshold), 128);
    check("stale_y_thr", int'(y_threshold), 128);
    check("stale_incdec", int'({x_increment, x_decrement, y_increment, y_decrement}), 0);
    $display("stale timeout: pulses=%0d x_thr=%0d x_inc=%0d", pulses, x_threshold, x_increment);
`else
    check("idle_pulses", pulses, 0);
    check("idle_x_thr", int'(x_threshold), 178);
    check("idle_x_inc", int'(x_increment), 1);
    $display("idle hold: pulses=%0d x_thr=%0d x_inc=%0d", pulses, x_threshold, x_increment);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tilt_encoder.md
Name: tilt_encoder

Overview:
Producer side of the ball-movement interface. Takes raw signed accelerometer X/Y samples through a valid/ready handshake and block-averages 2^AVG_LOG2 samples per axis. Each average is scaled to an 8-bit offset-binary tilt magnitude, and a per-axis hysteretic direction decision is made. Drives the ball block's x/y_increment, x/y_decrement and x/y_threshold inputs; threshold 128 means level.

Parameters:
SAMPLE_WIDTH, 12, width of signed two's-complement accelerometer samples
AVG_LOG2, 2, log2 of samples averaged per update; legal range 0..4
SCALE_SHIFT, 4, arithmetic right shift from averaged sample to scaled tilt
DEAD_ON, 16, scaled magnitude at which a neutral axis enters POS/NEG
DEAD_OFF, 8, scaled magnitude below which a POS/NEG axis returns to NEUTRAL; must be < DEAD_ON
STALE_CYCLES, 50000000, timeout in clk cycles; used only with optional feature

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
sample_valid  input  1  x_sample/y_sample valid
sample_ready  output  1  block can accept a sample
x_sample  input  SAMPLE_WIDTH  signed X acceleration
y_sample  input  SAMPLE_WIDTH  signed Y acceleration
x_increment  output  1  X axis in POS state
x_decrement  output  1  X axis in NEG state
y_increment  output  1  Y axis in POS state
y_decrement  output  1  Y axis in NEG state
x_threshold  output  8  X tilt, offset binary, 128 = level
y_threshold  output  8  Y tilt, offset binary, 128 = level
update_valid  output  1  one-cycle pulse when outputs refresh

Behaviour:
- Reset is asynchronous and active-high. All registers clear immediately.
- Reset values: sample_ready=0, all inc/dec=0, x/y_threshold=128, update_valid=0. The sample counter, both accumulators and both direction FSMs return to their initial state.
- Top FSM states: ACCUM and UPDATE. The first clock after reset deassertion enters ACCUM.
- ACCUM:
  - sample_ready=1.
  - A sample transfers only when sample_valid && sample_ready.
  - Each transfer adds the sign-extended sample to its accumulator. Accumulator width is SAMPLE_WIDTH+AVG_LOG2, so it never overflows.
  - The sample counter increments on each transfer.
  - The transfer that completes 2^AVG_LOG2 samples moves the FSM to UPDATE.
  - sample_valid while ready=0 is ignored; the source must hold the sample.
- UPDATE (exactly one cycle):
  - sample_ready=0.
  - avg = acc >>> AVG_LOG2 (arithmetic shift, floor toward -inf).
  - scaled = avg >>> SCALE_SHIFT.
  - threshold = saturate(scaled + 128) to 0..255.
  - Direction FSMs advance, accumulators and counter clear, and the block returns to ACCUM.
- Output timing:
  - Registered outputs change on the clock edge leaving UPDATE, and update_valid=1 for that following cycle.
  - Latency from the last sample's accept edge to new outputs: 2 clocks.
  - Throughput: one update per 2^AVG_LOG2+1 cycles with continuous valid.
- Per-axis direction FSM (NEUTRAL/POS/NEG), evaluated only in UPDATE:
  - NEUTRAL: scaled >= DEAD_ON goes to POS; scaled <= -DEAD_ON goes to NEG; otherwise stays.
  - POS: scaled <= -DEAD_ON goes to NEG directly; else scaled < DEAD_OFF goes to NEUTRAL; else stays.
  - NEG: mirror of POS.
  - increment = (state==POS) and decrement = (state==NEG); they are never both 1.
- threshold updates on every UPDATE regardless of direction state.
- X and Y are fully independent except for the shared handshake and counter.
- Reset mid-accumulation discards the partial sums. No update_valid is produced for the partial block.

Optional Feature:
- Macro: TILT_STALE_TIMEOUT_EN.
- When defined:
  - A counter counts clk cycles since the last accepted sample. It clears on every transfer and on reset.
  - When the count reaches STALE_CYCLES, the block forces both FSMs to NEUTRAL, sets thresholds to 128, and clears the accumulators and sample counter.
  - It pulses update_valid once; the counter then saturates with no repeat pulse.
  - The ball stops on sensor loss.
- When undefined: no counter exists, and outputs hold their last values indefinitely.

Test Plan:
- Four samples X=800 after reset -> update_valid pulse 2 clocks after the 4th accept; x_threshold=178, x_increment=1, x_decrement=0. With Y=0: y_threshold=128, y inc/dec=0.
- Four samples X=-2048, Y=2047 -> x_threshold=0, x_decrement=1; y_threshold=255, y_increment=1.
- Hysteresis on X:
  - From POS, block of 160s (scaled 10) -> stays POS, threshold 138.
  - Then block of 96s (scaled 6) -> NEUTRAL, threshold 134.
  - Then block of -320s (scaled -20) -> NEG.
- Mixed block X=100,200,300,400 from NEUTRAL -> avg 250, scaled 15, threshold 143, stays NEUTRAL. Also check ready=0 during UPDATE and that a held sample_valid is not double-counted.
- Assert reset after 2 of 4 samples -> outputs immediately return to reset values (thresholds 128). The next 4 samples of 800 produce threshold 178, showing the partial sums were dropped.
- With TILT_STALE_TIMEOUT_EN and STALE_CYCLES=20: drive to POS, then stop valid -> after 20 idle cycles, one update_valid pulse, inc/dec=0, thresholds=128, and no further pulse.
